// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : time-field limits, widths and the packed time record
// Rev 1.0
// ============================================================================
package stopwatch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_tick_gen.sv
`default_nettype none
// ============================================================================
// stopwatch_tick_gen : clock-enable divider, tick_o high while wrapping DIV-1->0
// Rev 1.0
// ============================================================================
module stopwatch_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;

  // A stopped divider keeps its partial period so resuming neither gains nor loses time.
  always_comb begin
    div_d  = div_q;
    tick_o = 1'b0;
    if (clear_i) begin
      div_d = '0;
    end else if (enable_i) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_o = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_dp.sv
`default_nettype none
// ============================================================================
// stopwatch_dp : centisecond/second/minute/hour counter chain with tick divider
// Optional lap freeze display enabled by macro STOPWATCH_LAP_EN.  Rev 1.0
// ============================================================================
module stopwatch_dp
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_runstop,
  input  logic              i_clear,
  input  logic              i_lap,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick,
  output logic              o_rollover
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  logic              w_tick;
  logic [MSEC_W-1:0] msec_q, msec_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick_q, tick_d;
  logic              roll_q, roll_d;
  time_t             live;

  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable_i (i_runstop),
    .clear_i  (i_clear),
    .tick_o   (w_tick)
  );

  // Full carry chain resolves in a single edge.
  always_comb begin
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    tick_d = 1'b0;
    roll_d = 1'b0;
    if (i_clear) begin
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (w_tick) begin
      tick_d = 1'b1;
      if (msec_q == MSEC_MAX) begin
        msec_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d = '0;
            if (hour_q == HOUR_MAX) begin
              hour_d = '0;
              roll_d = 1'b1;
            end else begin
              hour_d = hour_q + 1'b1;
            end
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end else begin
        msec_d = msec_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
      roll_q <= roll_d;
    end
  end

  assign live       = '{hour: hour_q, min: min_q, sec: sec_q, msec: msec_q};
  assign o_tick     = tick_q;
  assign o_rollover = roll_q;

`ifdef STOPWATCH_LAP_EN
  time_t lap_q, lap_d;
  logic  freeze_q, freeze_d;

  always_comb begin
    lap_d    = lap_q;
    freeze_d = freeze_q;
    if (i_clear) begin
      lap_d    = '0;
      freeze_d = 1'b0;
    end else if (i_lap) begin
      if (freeze_q) begin
        freeze_d = 1'b0;
      end else begin
        lap_d    = live;
        freeze_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      lap_q    <= lap_d;
      freeze_q <= freeze_d;
    end
  end

  // Display shows the lap snapshot while frozen; counting itself never pauses.
  assign {o_hour, o_min, o_sec, o_msec} = freeze_q ? lap_q : live;
`else
  logic unused_lap;
  assign unused_lap = i_lap;
  assign {o_hour, o_min, o_sec, o_msec} = live;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_dp.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_dp : directed bench for stopwatch_dp at DIV = 10
// Rev 1.0
// ============================================================================
module tb_stopwatch_dp;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_runstop;
  logic       i_clear;
  logic       i_lap;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;
  logic       o_rollover;

  int vectors = 0;
  int fails   = 0;

  stopwatch_dp #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_runstop  (i_runstop),
    .i_clear    (i_clear),
    .i_lap      (i_lap),
    .o_msec     (o_msec),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_tick     (o_tick),
    .o_rollover (o_rollover)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int cs);
    check({tag, ".hour"}, 32'(o_hour), 32'(h));
    check({tag, ".min"},  32'(o_min),  32'(m));
    check({tag, ".sec"},  32'(o_sec),  32'(s));
    check({tag, ".msec"}, 32'(o_msec), 32'(cs));
  endtask

  // Deposit internal state directly; only done while the counters are holding.
  task automatic preset(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic [6:0] cs, input logic [3:0] dv);
    dut.hour_q       = h;
    dut.min_q        = m;
    dut.sec_q        = s;
    dut.msec_q       = cs;
    dut.u_tick.div_q = dv;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    int first_t;
    int second_t;

    reset = 1'b0; i_runstop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;

    // Reset state
    step(2);
    check_time("reset", 0, 0, 0, 0);
    check("reset.tick", 32'(o_tick), 0);
    check("reset.roll", 32'(o_rollover), 0);

    // 25 enabled cycles -> two ticks at the 10th and 20th edges
    reset = 1'b1; i_runstop = 1'b1;
    ticks = 0; first_t = 0; second_t = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      if (o_tick === 1'b1) begin
        ticks++;
        if (ticks == 1) first_t = i;
        if (ticks == 2) second_t = i;
      end
    end
    check("run25.ticks", 32'(ticks), 2);
    check("run25.first", 32'(first_t), 10);
    check("run25.second", 32'(second_t), 20);
    check("run25.msec", 32'(o_msec), 2);

    // Stop mid-period, resume: partial period kept
    i_runstop = 1'b0;
    do_reset();
    i_runstop = 1'b1;
    step(6);
    i_runstop = 1'b0;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (o_tick === 1'b1) ticks++;
    end
    check("stop.ticks", 32'(ticks), 0);
    check("stop.msec", 32'(o_msec), 0);
    i_runstop = 1'b1;
    step(3);
    check("resume3.msec", 32'(o_msec), 0);
    step(1);
    check("resume4.msec", 32'(o_msec), 1);
    check("resume4.tick", 32'(o_tick), 1);

    // Second -> minute carry
    i_runstop = 1'b0;
    preset(5'd0, 6'd0, 6'd59, 7'd99, 4'd9);
    i_runstop = 1'b1;
    step(1);
    check_time("carry_min", 0, 1, 0, 0);
    check("carry_min.roll", 32'(o_rollover), 0);

    // Minute -> hour carry
    i_runstop = 1'b0;
    preset(5'd0, 6'd59, 6'd59, 7'd99, 4'd9);
    i_runstop = 1'b1;
    step(1);
    check_time("carry_hr", 1, 0, 0, 0);

    // Day rollover
    i_runstop = 1'b0;
    preset(5'd23, 6'd59, 6'd59, 7'd99, 4'd9);
    i_runstop = 1'b1;
    step(1);
    check_time("wrap", 0, 0, 0, 0);
    check("wrap.tick", 32'(o_tick), 1);
    check("wrap.roll", 32'(o_rollover), 1);
    step(1);
    check("wrap+1.tick", 32'(o_tick), 0);
    check("wrap+1.roll", 32'(o_rollover), 0);
    step(9);
    check("wrap+10.msec", 32'(o_msec), 1);

    // Clear while running dominates run
    i_runstop = 1'b0;
    preset(5'd0, 6'd0, 6'd5, 7'd37, 4'd4);
    i_runstop = 1'b1;
    step(2);
    check_time("pre_clear", 0, 0, 5, 37);
    i_clear = 1'b1;
    step(1);
    check_time("clear", 0, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (o_tick === 1'b1) ticks++;
    end
    check("clear_hold.ticks", 32'(ticks), 0);
    check("clear_hold.msec", 32'(o_msec), 0);
    i_clear = 1'b0;
    step(10);
    check("post_clear.msec", 32'(o_msec), 1);

    // Reset mid-run
    i_runstop = 1'b0;
    preset(5'd3, 6'd4, 6'd5, 7'd42, 4'd9);
    i_runstop = 1'b1;
    reset = 1'b0;
    step(1);
    check_time("midreset", 0, 0, 0, 0);
    check("midreset.tick", 32'(o_tick), 0);
    reset = 1'b1;

`ifdef STOPWATCH_LAP_EN
    // Lap freeze: display holds while live counting continues
    i_runstop = 1'b0;
    step(1);
    preset(5'd0, 6'd0, 6'd1, 7'd20, 4'd0);
    i_runstop = 1'b1;
    i_lap = 1'b1;
    step(1);
    i_lap = 1'b0;
    check_time("lap", 0, 0, 1, 20);
    ticks = 0;
    for (int i = 0; i < 299; i++) begin
      step(1);
      if (o_tick === 1'b1) ticks++;
    end
    check("lap.ticks", 32'(ticks), 30);
    check_time("lap_hold", 0, 0, 1, 20);
    i_lap = 1'b1;
    step(1);
    i_lap = 1'b0;
    check_time("lap_release", 0, 0, 1, 50);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
